// File: rtl/cnn_pkg.sv
// Shared types for the CNN pooling datapath: feature word, channel count,
// pooling FSM states and a signed max helper.
package cnn_pkg;

    typedef logic signed [15:0] feature_t;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic feature_t smax(feature_t a, feature_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_channel.sv
// One channel of 2x2/stride-2 max pooling: optional ReLU, horizontal hold
// register, half-width line buffer and registered result. Macro: POOL_RELU_EN.
module pool_channel
    import cnn_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  feature_t         pixel,
    input  logic             hold_en,
    input  logic             buf_en,
    input  logic             out_en,
    input  logic [IDX_W-1:0] idx,
    output feature_t         result
);

    feature_t px;
    feature_t hold_q;
    feature_t line_q [DEPTH];

    always_comb begin
`ifdef POOL_RELU_EN
        px = pixel[15] ? feature_t'(0) : pixel;
`else
        px = pixel;
`endif
    end

    // hold_q carries the even-column pixel on both even and odd rows
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_q <= '0;
            result <= '0;
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            if (hold_en) hold_q <= px;
            if (buf_en) line_q[idx] <= smax(hold_q, px);
            if (out_en) result <= smax(line_q[idx], smax(hold_q, px));
        end
    end

endmodule

// File: rtl/pool_layer.sv
// 2x2 stride-2 max-pool layer: frame FSM and row/col counters driving NUM_CH
// pool_channel slices. Optional input ReLU via macro POOL_RELU_EN.
module pool_layer
    import cnn_pkg::*;
#(
    parameter int IN_W = 24,
    parameter int IN_H = 24
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    input  logic                in_valid,
    input  feature_t [NUM_CH:1] in_feature,
    output feature_t [NUM_CH:1] out_feature,
    output logic                out_valid,
    output logic                frame_done,
    output logic                busy
);

    localparam int DEPTH = IN_W / 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H);

    if (IN_W % 2 != 0) begin : g_bad_w
        $error("pool_layer: IN_W must be even");
    end
    if (IN_H % 2 != 0) begin : g_bad_h
        $error("pool_layer: IN_H must be even");
    end

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             last_px;
    logic             accept;
    logic             last_pos;
    logic             hold_en;
    logic             buf_en;
    logic             out_en;
    logic [IDX_W-1:0] idx;

    // start in RUN wins over a coincident pixel; nothing is taken after the last one
    assign accept   = (state == RUN) && in_valid && !start && !last_px;
    assign last_pos = (col == CW'(IN_W - 1)) && (row == RW'(IN_H - 1));
    assign hold_en  = accept && !col[0];
    assign buf_en   = accept && !row[0] && col[0];
    assign out_en   = accept && row[0] && col[0];
    assign idx      = IDX_W'(col >> 1);

    // DONE follows the final strobe by one cycle so frame_done trails it
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            last_px    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid  <= out_en;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        col     <= '0;
                        row     <= '0;
                        last_px <= 1'b0;
                    end else if (last_px) begin
                        state      <= DONE;
                        last_px    <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (accept) begin
                        if (last_pos) last_px <= 1'b1;
                        if (col == CW'(IN_W - 1)) begin
                            col <= '0;
                            row <= (row == RW'(IN_H - 1)) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar ch = 1; ch <= NUM_CH; ch++) begin : g_ch
        pool_channel #(
            .DEPTH(DEPTH),
            .IDX_W(IDX_W)
        ) u_ch (
            .clk     (clk),
            .n_reset (n_reset),
            .pixel   (in_feature[ch]),
            .hold_en (hold_en),
            .buf_en  (buf_en),
            .out_en  (out_en),
            .idx     (idx),
            .result  (out_feature[ch])
        );
    end

endmodule

// File: tb/tb_pool_layer.sv
// Bench for pool_layer: 2x2 table vectors, 4x4 directed/corner sequences and a
// random 24x24 frame against a window-max reference model.
module tb_pool_layer;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    feature_t [NUM_CH:1] in_feature = '0;

    feature_t [NUM_CH:1] of2, of4, of24;
    logic ov2, ov4, ov24, fd2, fd4, fd24, b2, b4, b24;

    always #5 clk = ~clk;

    pool_layer #(.IN_W(2), .IN_H(2)) dut2 (
        .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid),
        .in_feature(in_feature), .out_feature(of2), .out_valid(ov2),
        .frame_done(fd2), .busy(b2));
    pool_layer #(.IN_W(4), .IN_H(4)) dut4 (
        .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid),
        .in_feature(in_feature), .out_feature(of4), .out_valid(ov4),
        .frame_done(fd4), .busy(b4));
    pool_layer dut24 (
        .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid),
        .in_feature(in_feature), .out_feature(of24), .out_valid(ov24),
        .frame_done(fd24), .busy(b24));

    int sel = 1;
    feature_t [NUM_CH:1] o_feat;
    logic o_valid, o_done, o_busy;

    always_comb begin
        o_feat = of4; o_valid = ov4; o_done = fd4; o_busy = b4;
        case (sel)
            0: begin o_feat = of2;  o_valid = ov2;  o_done = fd2;  o_busy = b2;  end
            2: begin o_feat = of24; o_valid = ov24; o_done = fd24; o_busy = b24; end
            default: ;
        endcase
    end

    int n_chk = 0;
    int n_pass = 0;
    int cur_w = 4;
    int cur_h = 4;
    feature_t pix [576][4];
    int got1 [$];

    typedef struct {
        int p [4];
        int e_plain;
        int e_relu;
    } vec_t;
    vec_t tbl [6];
    int ramp_exp [4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    endtask

    function automatic int relu(input int v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // reference: max of the four (optionally rectified) pixels of a window
    function automatic int ref_win(input int ch, input int wr, input int wc);
        int m;
        m = -100000;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                int v;
                v = relu(int'(pix[(2*wr+dr)*cur_w + 2*wc + dc][ch]));
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            for (int ch = 1; ch <= NUM_CH; ch++) pix[i][ch] = feature_t'($urandom);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
        tick();
    endtask

    task automatic do_start(input bit junk);
        got1.delete();
        in_valid = junk;
        for (int ch = 1; ch <= NUM_CH; ch++) in_feature[ch] = feature_t'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_start", int'(o_busy), 1);
    endtask

    task automatic drive_px(input int idx, input int gap);
        int r, c;
        bit br;
        r = idx / cur_w;
        c = idx % cur_w;
        br = (r % 2 == 1) && (c % 2 == 1);
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
            chk("gap_no_strobe", int'(o_valid), 0);
        end
        for (int ch = 1; ch <= NUM_CH; ch++) in_feature[ch] = pix[idx][ch];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("strobe_timing", int'(o_valid), int'(br));
        chk("busy_in_run", int'(o_busy), 1);
        if (o_valid) got1.push_back(int'(o_feat[1]));
        if (br)
            for (int ch = 1; ch <= NUM_CH; ch++)
                chk("pool_value", int'(o_feat[ch]), ref_win(ch, r / 2, c / 2));
    endtask

    task automatic run_frame(input int maxgap, input bit junk);
        do_start(junk);
        for (int i = 0; i < cur_w * cur_h; i++) drive_px(i, $urandom_range(maxgap, 0));
        tick();
        chk("frame_done_set", int'(o_done), 1);
        chk("no_extra_strobe", int'(o_valid), 0);
        chk("busy_after_frame", int'(o_busy), 0);
        tick();
        chk("frame_done_pulse", int'(o_done), 0);
        chk("strobe_count", got1.size(), (cur_w / 2) * (cur_h / 2));
        chk("out_hold", int'(o_feat[1]), ref_win(1, cur_h / 2 - 1, cur_w / 2 - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        tbl[0] = '{'{-5, -3, -7, -1}, -1, 0};
        tbl[1] = '{'{1, 2, 3, 4}, 4, 4};
        tbl[2] = '{'{32767, -32768, 0, 5}, 32767, 32767};
        tbl[3] = '{'{-32768, -32768, -32768, -32768}, -32768, 0};
        tbl[4] = '{'{100, -100, 200, -200}, 200, 200};
        tbl[5] = '{'{-2, 0, -1, -3}, 0, 0};
        ramp_exp = '{6, 8, 14, 16};

        // reset state
        #2 n_reset = 1'b0;
        @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_valid", int'(o_valid), 0);
            chk("rst_done", int'(o_done), 0);
            chk("rst_busy", int'(o_busy), 0);
            for (int ch = 1; ch <= NUM_CH; ch++) chk("rst_feat", int'(o_feat[ch]), 0);
        end
        @(negedge clk);
        n_reset = 1'b1;
        tick();

        // single-window table on the 2x2 instance
        sel = 0; cur_w = 2; cur_h = 2;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                pix[k][1] = feature_t'(tbl[i].p[k]);
                pix[k][2] = feature_t'(tbl[i].p[3 - k]);
                pix[k][3] = feature_t'(tbl[i].p[(k + 1) % 4]);
            end
            run_frame(0, 1'b0);
`ifdef POOL_RELU_EN
            e = tbl[i].e_relu;
`else
            e = tbl[i].e_plain;
`endif
            for (int ch = 1; ch <= NUM_CH; ch++) chk("table_vec", int'(o_feat[ch]), e);
        end

        // 4x4 ramp, start coinciding with a stray pixel in IDLE
        do_reset();
        sel = 1; cur_w = 4; cur_h = 4;
        fill_random(16);
        for (int i = 0; i < 16; i++) pix[i][1] = feature_t'(i + 1);
        run_frame(0, 1'b1);
        for (int k = 0; k < 4; k++)
            chk("ramp_ch1", (k < got1.size()) ? got1[k] : -99999, ramp_exp[k]);

        // pixels while IDLE are ignored and the output holds
        for (int k = 0; k < 3; k++) begin
            for (int ch = 1; ch <= NUM_CH; ch++) in_feature[ch] = feature_t'($urandom);
            in_valid = 1'b1;
            tick();
            chk("idle_no_strobe", int'(o_valid), 0);
            chk("idle_hold", int'(o_feat[1]), 16);
        end
        in_valid = 1'b0;

        // same ramp with random gaps
        run_frame(3, 1'b0);
        for (int k = 0; k < 4; k++)
            chk("gap_ramp_ch1", (k < got1.size()) ? got1[k] : -99999, ramp_exp[k]);

        // restart after 5 pixels
        fill_random(16);
        do_start(1'b0);
        for (int i = 0; i < 5; i++) drive_px(i, 0);
        fill_random(16);
        run_frame(1, 1'b0);

        // reset during pixel 10, then a clean frame
        fill_random(16);
        do_start(1'b0);
        for (int i = 0; i < 9; i++) drive_px(i, 0);
        for (int ch = 1; ch <= NUM_CH; ch++) in_feature[ch] = pix[9][ch];
        in_valid = 1'b1;
        n_reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        for (int ch = 1; ch <= NUM_CH; ch++) chk("mid_rst_feat", int'(o_feat[ch]), 0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_no_done", int'(o_done), 0);
        end
        n_reset = 1'b1;
        tick();
        chk("post_rst_idle", int'(o_busy), 0);
        fill_random(16);
        run_frame(0, 1'b0);

        // full-size random frame
        do_reset();
        sel = 2; cur_w = 24; cur_h = 24;
        fill_random(576);
        run_frame(1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
